fft_stream_framer: RTL and testbench

//  Frames a continuous complex sample stream for the FFT core's AXI-Stream slave ports.
//  - Issues one config transaction before the first frame, and again whenever the

---
 rtl/fft_stream_framer.sv | 156 +++++++++++++++
 tb/tb_fft_stream_framer.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_stream_framer.sv
// Frames a continuous complex sample stream into FRAME_LEN-sample AXI-Stream frames for fft_core.
// Issues a config beat before streaming and on direction changes; zero-pads an open frame on stop.
module fft_stream_framer #(
    parameter int DATA_W    = 16,
    parameter int FRAME_LEN = 128,
    parameter int CFG_W     = 8,
    parameter int CNT_W     = 16
) (
    input  logic                aclk,
    input  logic                areset,
    input  logic                enable,
    input  logic                fwd_inv,
    input  logic                s_in_tvalid,
    output logic                s_in_tready,
    input  logic [2*DATA_W-1:0] s_in_tdata,
    output logic                m_config_tvalid,
    input  logic                m_config_tready,
    output logic [CFG_W-1:0]    m_config_tdata,
    output logic                m_data_tvalid,
    input  logic                m_data_tready,
    output logic [2*DATA_W-1:0] m_data_tdata,
    output logic                m_data_tlast,
    output logic [CNT_W-1:0]    frame_count,
    output logic                busy
);
    localparam int              SW       = $clog2(FRAME_LEN);
    localparam int              DW       = 2 * DATA_W;
    localparam logic [SW-1:0]   LAST_IDX = SW'(FRAME_LEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_CFG, S_STREAM, S_PAD} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [SW-1:0]    r_cnt;
    logic             r_fwd_inv_lat;
    logic [CNT_W-1:0] r_frame_cnt;

    // Skid buffer: head entry drives the output port directly, skid entry holds overflow.
    logic [1:0]       r_occ;
    logic [DW-1:0]    r_head_data;
    logic [DW-1:0]    r_skid_data;
    logic             r_head_last;
    logic             r_skid_last;

    logic             w_space;
    logic             w_rd;
    logic             w_wr;
    logic             w_wr_last;
    logic             w_at_start;
    logic             w_latch;
    logic [DW-1:0]    w_wr_data;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        w_space     = (r_occ != 2'd2) || m_data_tready;
        w_rd        = (r_occ != 2'd0) && m_data_tready;
        w_wr_last   = (r_cnt == LAST_IDX);
        w_at_start  = (r_cnt == '0);
        w_state_nxt = r_state;
        s_in_tready = 1'b0;
        w_wr        = 1'b0;
        w_wr_data   = '0;
        w_latch     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_latch     = 1'b1;
                    w_state_nxt = S_CFG;
                end
            end
            S_CFG: begin
                if (m_config_tready) w_state_nxt = S_STREAM;
            end
            S_STREAM: begin
                // A new frame is only opened when neither a stop nor a direction change is pending.
                s_in_tready = w_space && enable && (!w_at_start || (fwd_inv == r_fwd_inv_lat));
                w_wr        = s_in_tready && s_in_tvalid;
                w_wr_data   = s_in_tdata;
                if (w_at_start || (w_wr && w_wr_last)) begin
                    if (!enable) begin
                        w_state_nxt = S_IDLE;
                    end else if (fwd_inv != r_fwd_inv_lat) begin
                        w_latch     = 1'b1;
                        w_state_nxt = S_CFG;
                    end
                end else if (!enable) begin
                    w_state_nxt = S_PAD;
                end
            end
            S_PAD: begin
                w_wr = w_space;
                if (w_wr && w_wr_last) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_fwd_inv_lat <= 1'b1;
            r_frame_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_latch) r_fwd_inv_lat <= fwd_inv;
            if (w_wr) r_cnt <= w_wr_last ? '0 : r_cnt + 1'b1;
            if (w_rd && r_head_last) r_frame_cnt <= r_frame_cnt + 1'b1;
        end
    end

    // NOTE: buffer data is reset too, because the output ports it drives must read 0 in reset.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_occ       <= 2'd0;
            r_head_data <= '0;
            r_head_last <= 1'b0;
            r_skid_data <= '0;
            r_skid_last <= 1'b0;
        end else begin
            r_occ <= r_occ + {1'b0, w_wr} - {1'b0, w_rd};
            if (w_rd) begin
                if (r_occ == 2'd2) begin
                    r_head_data <= r_skid_data;
                    r_head_last <= r_skid_last;
                    if (w_wr) begin
                        r_skid_data <= w_wr_data;
                        r_skid_last <= w_wr_last;
                    end
                end else if (w_wr) begin
                    r_head_data <= w_wr_data;
                    r_head_last <= w_wr_last;
                end
            end else if (w_wr) begin
                if (r_occ == 2'd0) begin
                    r_head_data <= w_wr_data;
                    r_head_last <= w_wr_last;
                end else begin
                    r_skid_data <= w_wr_data;
                    r_skid_last <= w_wr_last;
                end
            end
        end
    end

    assign m_config_tvalid = (r_state == S_CFG);
    assign m_config_tdata  = {{(CFG_W-1){1'b0}}, r_fwd_inv_lat & m_config_tvalid};
    assign m_data_tvalid   = (r_occ != 2'd0);
    assign m_data_tdata    = r_head_data;
    assign m_data_tlast    = r_head_last;
    assign frame_count     = r_frame_cnt;
    assign busy            = (r_state != S_IDLE) || (r_occ != 2'd0);

endmodule

// File: tb/tb_fft_stream_framer.sv
// Self-checking bench for fft_stream_framer: a queue-based source/sink with a frame-level
// reference model (tlast every FRAME_LEN-th sample, zero padding on stop).
module tb_fft_stream_framer;
    localparam int DATA_W    = 16;
    localparam int FRAME_LEN = 8;
    localparam int CFG_W     = 8;
    localparam int CNT_W     = 16;

    logic                aclk = 1'b0;
    logic                areset;
    logic                enable;
    logic                fwd_inv;
    logic                s_in_tvalid;
    logic                s_in_tready;
    logic [2*DATA_W-1:0] s_in_tdata;
    logic                m_config_tvalid;
    logic                m_config_tready;
    logic [CFG_W-1:0]    m_config_tdata;
    logic                m_data_tvalid;
    logic                m_data_tready;
    logic [2*DATA_W-1:0] m_data_tdata;
    logic                m_data_tlast;
    logic [CNT_W-1:0]    frame_count;
    logic                busy;

    always #5 aclk = ~aclk;

    fft_stream_framer #(
        .DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN), .CFG_W(CFG_W), .CNT_W(CNT_W)
    ) dut (
        .aclk(aclk), .areset(areset), .enable(enable), .fwd_inv(fwd_inv),
        .s_in_tvalid(s_in_tvalid), .s_in_tready(s_in_tready), .s_in_tdata(s_in_tdata),
        .m_config_tvalid(m_config_tvalid), .m_config_tready(m_config_tready),
        .m_config_tdata(m_config_tdata),
        .m_data_tvalid(m_data_tvalid), .m_data_tready(m_data_tready),
        .m_data_tdata(m_data_tdata), .m_data_tlast(m_data_tlast),
        .frame_count(frame_count), .busy(busy)
    );

    int          checks = 0;
    int          failures = 0;
    logic [31:0] src_q[$];
    logic [31:0] sent_q[$];
    logic [32:0] got_q[$];
    int          got_cyc[$];
    logic [32:0] exp_q[$];
    logic [7:0]  cfg_q[$];
    int          cfg_at[$];
    int          n_acc;
    int          cyc;
    bit          in_fire;
    bit          hold_pend;
    logic [32:0] hold_val;
    int          rdy_mode;
    bit          src_gappy;

    task automatic drive_src();
        if (s_in_tvalid && !in_fire) return;
        if (src_q.size() != 0 && (!src_gappy || $urandom_range(0, 3) != 0)) begin
            s_in_tvalid = 1'b1;
            s_in_tdata  = src_q[0];
        end else begin
            s_in_tvalid = 1'b0;
            s_in_tdata  = '0;
        end
    endtask

    // One clock: observe handshakes at the falling edge, update stimulus just after the rising edge.
    task automatic step();
        @(negedge aclk);
        cyc++;
        if (hold_pend) begin
            checks++;
            if (m_data_tvalid !== 1'b1 || {m_data_tlast, m_data_tdata} !== hold_val) begin
                failures++;
                $display("FAIL stall_hold valid=%b got=%h exp=%h", m_data_tvalid,
                         {m_data_tlast, m_data_tdata}, hold_val);
            end
        end
        hold_pend = m_data_tvalid && !m_data_tready;
        hold_val  = {m_data_tlast, m_data_tdata};
        if (m_data_tvalid && m_data_tready) begin
            got_q.push_back({m_data_tlast, m_data_tdata});
            got_cyc.push_back(cyc);
        end
        if (m_config_tvalid && m_config_tready) begin
            cfg_q.push_back(m_config_tdata);
            cfg_at.push_back(got_q.size());
        end
        in_fire = s_in_tvalid && s_in_tready;
        @(posedge aclk);
        #1;
        if (in_fire) begin
            void'(src_q.pop_front());
            n_acc++;
        end
        drive_src();
        case (rdy_mode)
            1:       m_data_tready = !m_data_tready;
            2:       m_data_tready = 1'($urandom_range(0, 1));
            default: m_data_tready = 1'b1;
        endcase
    endtask

    task automatic clear_queues();
        src_q.delete(); sent_q.delete(); got_q.delete(); got_cyc.delete();
        exp_q.delete(); cfg_q.delete(); cfg_at.delete();
        n_acc = 0; in_fire = 1'b0; hold_pend = 1'b0;
    endtask

    task automatic do_reset();
        areset = 1'b1; enable = 1'b0; fwd_inv = 1'b1;
        s_in_tvalid = 1'b0; s_in_tdata = '0;
        m_config_tready = 1'b1; m_data_tready = 1'b1;
        rdy_mode = 0; src_gappy = 1'b0;
        clear_queues();
        repeat (2) @(posedge aclk);
        #1 areset = 1'b0;
    endtask

    task automatic load(input int n, input bit ramp);
        for (int i = 0; i < n; i++) begin
            logic [31:0] v;
            v = ramp ? 32'(i + 1) : $urandom;
            src_q.push_back(v);
            sent_q.push_back(v);
        end
        drive_src();
    endtask

    // Reference: every sample in order, tlast on each FRAME_LEN-th, zero-filled to a frame edge on stop.
    task automatic model_build(input bit flush);
        exp_q.delete();
        for (int i = 0; i < sent_q.size(); i++)
            exp_q.push_back({(((i + 1) % FRAME_LEN) == 0), sent_q[i]});
        if (flush)
            while (exp_q.size() % FRAME_LEN != 0)
                exp_q.push_back({((exp_q.size() % FRAME_LEN) == FRAME_LEN - 1), 32'h0});
    endtask

    task automatic wait_beats(input int n, input int budget, output bit ok);
        for (int k = 0; k < budget && got_q.size() < n; k++) step();
        ok = (got_q.size() >= n);
    endtask

    task automatic wait_acc(input int n, input int budget, output bit ok);
        for (int k = 0; k < budget && n_acc < n; k++) step();
        ok = (n_acc >= n);
    endtask

    task automatic test_reset();
        areset = 1'b1; enable = 1'b1; fwd_inv = 1'b0;
        m_config_tready = 1'b1; m_data_tready = 1'b1;
        s_in_tvalid = 1'b1; s_in_tdata = 32'hdead_beef;
        @(negedge aclk); @(negedge aclk);
        checks++; if (s_in_tready !== 1'b0) begin failures++; $display("FAIL rst_s_in_tready got=%b exp=0", s_in_tready); end
        checks++; if (m_config_tvalid !== 1'b0) begin failures++; $display("FAIL rst_cfg_valid got=%b exp=0", m_config_tvalid); end
        checks++; if (m_config_tdata !== 8'h00) begin failures++; $display("FAIL rst_cfg_data got=%h exp=00", m_config_tdata); end
        checks++; if (m_data_tvalid !== 1'b0) begin failures++; $display("FAIL rst_data_valid got=%b exp=0", m_data_tvalid); end
        checks++; if (m_data_tdata !== 32'h0) begin failures++; $display("FAIL rst_data got=%h exp=0", m_data_tdata); end
        checks++; if (m_data_tlast !== 1'b0) begin failures++; $display("FAIL rst_tlast got=%b exp=0", m_data_tlast); end
        checks++; if (frame_count !== 16'h0) begin failures++; $display("FAIL rst_frame_count got=%0d exp=0", frame_count); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
        do_reset();
        repeat (3) step();
        checks++; if (m_config_tvalid !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL idle_hold cfg_valid=%b busy=%b exp=0,0", m_config_tvalid, busy);
        end
    endtask

    task automatic test_basic();
        bit ok;
        do_reset();
        enable = 1'b1; fwd_inv = 1'b1;
        load(16, 1'b1);
        model_build(1'b0);
        wait_beats(16, 100, ok);
        checks++; if (!ok) begin failures++; $display("FAIL basic_timeout got=%0d beats exp=16", got_q.size()); end
        checks++; if (cfg_q.size() != 1 || cfg_q[0] !== 8'h01) begin
            failures++; $display("FAIL basic_cfg count=%0d first=%h exp=1,01", cfg_q.size(), cfg_q.size() ? cfg_q[0] : 8'hxx);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL basic_beat[%0d] got=%h exp=%h", i, i < got_q.size() ? got_q[i] : 33'hx, exp_q[i]);
            end
        end
        checks++; if (got_q.size() == 16 && got_cyc[15] - got_cyc[0] != 15) begin
            failures++; $display("FAIL basic_throughput span=%0d exp=15", got_cyc[15] - got_cyc[0]);
        end
        checks++; if (frame_count !== 16'd2) begin failures++; $display("FAIL basic_frame_count got=%0d exp=2", frame_count); end
    endtask

    task automatic test_backpressure();
        bit ok;
        do_reset();
        enable = 1'b1; rdy_mode = 1;
        load(16, 1'b1);
        model_build(1'b0);
        wait_beats(16, 200, ok);
        checks++; if (!ok) begin failures++; $display("FAIL bp_timeout got=%0d beats exp=16", got_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL bp_beat[%0d] got=%h exp=%h", i, i < got_q.size() ? got_q[i] : 33'hx, exp_q[i]);
            end
        end
        checks++; if (frame_count !== 16'd2) begin failures++; $display("FAIL bp_frame_count got=%0d exp=2", frame_count); end
    endtask

    task automatic test_pad();
        bit ok;
        do_reset();
        enable = 1'b1;
        load(3, 1'b1);
        wait_acc(3, 50, ok);
        checks++; if (!ok) begin failures++; $display("FAIL pad_accept_timeout got=%0d exp=3", n_acc); end
        enable = 1'b0;
        src_q.push_back(32'h99);
        model_build(1'b1);
        wait_beats(8, 60, ok);
        checks++; if (!ok) begin failures++; $display("FAIL pad_timeout got=%0d beats exp=8", got_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL pad_beat[%0d] got=%h exp=%h", i, i < got_q.size() ? got_q[i] : 33'hx, exp_q[i]);
            end
        end
        repeat (2) step();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL pad_busy got=%b exp=0", busy); end
        repeat (10) step();
        checks++; if (got_q.size() != 8 || cfg_q.size() != 1 || n_acc != 3) begin
            failures++; $display("FAIL pad_quiet beats=%0d cfgs=%0d accepted=%0d exp=8,1,3", got_q.size(), cfg_q.size(), n_acc);
        end
    endtask

    task automatic test_dir_change();
        bit ok;
        do_reset();
        enable = 1'b1; fwd_inv = 1'b1;
        load(16, 1'b1);
        model_build(1'b0);
        wait_acc(4, 50, ok);
        fwd_inv = 1'b0;
        wait_beats(16, 100, ok);
        checks++; if (!ok) begin failures++; $display("FAIL dir_timeout got=%0d beats exp=16", got_q.size()); end
        checks++; if (cfg_q.size() != 2 || cfg_q[0] !== 8'h01 || cfg_q[1] !== 8'h00) begin
            failures++; $display("FAIL dir_cfg count=%0d exp=2 beats 01,00", cfg_q.size());
        end
        checks++; if (cfg_at.size() == 2 && (cfg_at[1] < 7 || cfg_at[1] > 8)) begin
            failures++; $display("FAIL dir_cfg_order data_beats_before=%0d exp=7..8", cfg_at[1]);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL dir_beat[%0d] got=%h exp=%h", i, i < got_q.size() ? got_q[i] : 33'hx, exp_q[i]);
            end
        end
    endtask

    task automatic test_cfg_stall();
        bit ok;
        do_reset();
        m_config_tready = 1'b0; enable = 1'b1;
        load(8, 1'b1);
        model_build(1'b0);
        step();
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (m_config_tvalid !== 1'b1 || m_config_tdata !== 8'h01 || s_in_tready !== 1'b0 || m_data_tvalid !== 1'b0) begin
                failures++; $display("FAIL cfg_stall[%0d] cfg_v=%b cfg_d=%h in_rdy=%b data_v=%b exp=1,01,0,0",
                                     k, m_config_tvalid, m_config_tdata, s_in_tready, m_data_tvalid);
            end
            step();
        end
        m_config_tready = 1'b1;
        wait_beats(8, 60, ok);
        checks++; if (!ok) begin failures++; $display("FAIL cfg_stall_timeout got=%0d beats exp=8", got_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL cfg_stall_beat[%0d] got=%h exp=%h", i, i < got_q.size() ? got_q[i] : 33'hx, exp_q[i]);
            end
        end
        checks++; if (cfg_q.size() != 1) begin failures++; $display("FAIL cfg_stall_count got=%0d exp=1", cfg_q.size()); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_reset();
        enable = 1'b1;
        load(16, 1'b1);
        // Fifth sample of the second frame, so a completed frame is on the counter when reset hits.
        wait_acc(13, 60, ok);
        checks++; if (!ok || frame_count !== 16'd1) begin
            failures++; $display("FAIL mid_pre_reset accepted=%0d frame_count=%0d exp=13,1", n_acc, frame_count);
        end
        areset = 1'b1;
        #1;
        checks++;
        if ({s_in_tready, m_config_tvalid, m_config_tdata, m_data_tvalid, m_data_tdata, m_data_tlast, frame_count, busy} !== '0) begin
            failures++; $display("FAIL mid_reset_outputs in_rdy=%b cfg_v=%b cfg_d=%h v=%b d=%h last=%b fc=%0d busy=%b exp=all 0",
                                 s_in_tready, m_config_tvalid, m_config_tdata, m_data_tvalid, m_data_tdata,
                                 m_data_tlast, frame_count, busy);
        end
        s_in_tvalid = 1'b0;
        clear_queues();
        repeat (2) @(posedge aclk);
        #1 areset = 1'b0;
        load(8, 1'b1);
        model_build(1'b0);
        wait_beats(8, 60, ok);
        checks++; if (!ok) begin failures++; $display("FAIL mid_timeout got=%0d beats exp=8", got_q.size()); end
        checks++; if (cfg_q.size() != 1 || cfg_q[0] !== 8'h01) begin
            failures++; $display("FAIL mid_cfg count=%0d exp=1 beat 01", cfg_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL mid_beat[%0d] got=%h exp=%h", i, i < got_q.size() ? got_q[i] : 33'hx, exp_q[i]);
            end
        end
        checks++; if (frame_count !== 16'd1) begin failures++; $display("FAIL mid_frame_count got=%0d exp=1", frame_count); end
    endtask

    task automatic test_random(input int iter);
        bit ok;
        int n;
        logic fwd;
        do_reset();
        rdy_mode = 2; src_gappy = 1'b1;
        fwd = 1'($urandom_range(0, 1));
        fwd_inv = fwd; enable = 1'b1;
        n = $urandom_range(3, 30);
        load(n, 1'b0);
        wait_acc(n, 400, ok);
        checks++; if (!ok) begin failures++; $display("FAIL rnd%0d_accept_timeout got=%0d exp=%0d", iter, n_acc, n); end
        enable = 1'b0;
        model_build(1'b1);
        wait_beats(exp_q.size(), 400, ok);
        checks++; if (!ok) begin failures++; $display("FAIL rnd%0d_timeout got=%0d exp=%0d", iter, got_q.size(), exp_q.size()); end
        repeat (4) step();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rnd%0d_busy got=%b exp=0", iter, busy); end
        checks++; if (cfg_q.size() != 1 || cfg_q[0] !== {7'h0, fwd}) begin
            failures++; $display("FAIL rnd%0d_cfg count=%0d exp=1 beat %h", iter, cfg_q.size(), {7'h0, fwd});
        end
        checks++; if (got_q.size() != exp_q.size()) begin
            failures++; $display("FAIL rnd%0d_count got=%0d exp=%0d", iter, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL rnd%0d_beat[%0d] got=%h exp=%h", iter, i, i < got_q.size() ? got_q[i] : 33'hx, exp_q[i]);
            end
        end
        checks++; if (frame_count !== 16'(exp_q.size() / FRAME_LEN)) begin
            failures++; $display("FAIL rnd%0d_frame_count got=%0d exp=%0d", iter, frame_count, exp_q.size() / FRAME_LEN);
        end
    endtask

    initial begin
        cyc = 0;
        clear_queues();
        test_reset();
        test_basic();
        test_backpressure();
        test_pad();
        test_dir_change();
        test_cfg_stall();
        test_reset_mid();
        for (int it = 0; it < 3; it++) test_random(it);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
